// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC execute unit: opcodes, ALU functions,
// ALU operand modes, sequencer states and status-register bit positions.
package sisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_BRA  = 4'h4;
  localparam logic [3:0] OP_BRR  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BNR  = 4'h7;
  localparam logic [3:0] OP_LOD  = 4'h8;
  localparam logic [3:0] OP_STR  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] FN_ADD = 4'h1;
  localparam logic [3:0] FN_SUB = 4'h2;
  localparam logic [3:0] FN_AND = 4'h3;
  localparam logic [3:0] FN_OR  = 4'h4;
  localparam logic [3:0] FN_XOR = 4'h5;
  localparam logic [3:0] FN_NOT = 4'h6;
  localparam logic [3:0] FN_SHL = 4'h7;
  localparam logic [3:0] FN_SHR = 4'h8;

  localparam logic [1:0] AOP_REG  = 2'b00;
  localparam logic [1:0] AOP_IMM  = 2'b01;
  localparam logic [1:0] AOP_ADDR = 2'b10;
  localparam logic [1:0] AOP_PASS = 2'b11;

  localparam int SR_C = 3;
  localparam int SR_V = 2;
  localparam int SR_N = 1;
  localparam int SR_Z = 0;

  typedef enum logic [2:0] {
    ST_START0, ST_START1, ST_FETCH, ST_DECODE,
    ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_HALT
  } state_t;

endpackage

// File: rtl/sisc_alu_core.sv
// Combinational 32-bit ALU: operand-B selection by ALU mode, function
// select, and C/V/N/Z status generation.
module sisc_alu_core
  import sisc_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_rsb,
  input  logic [15:0] i_imm,
  input  logic [3:0]  i_fn,
  input  logic [1:0]  i_alu_op,
  output logic [31:0] o_result,
  output logic [3:0]  o_stat
);

  logic [31:0] w_b;
  logic [3:0]  w_fn;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_c;
  logic        w_v;

  always_comb begin
    w_b  = i_rsb;
    w_fn = i_fn;
    case (i_alu_op)
      AOP_IMM:  w_b = {{16{i_imm[15]}}, i_imm};
      AOP_ADDR: begin
        w_b  = {16'h0000, i_imm};
        w_fn = FN_ADD;
      end
      default: ;
    endcase
  end

  // Subtraction as a + ~b + 1 so bit 32 is directly NOT borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, w_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~w_b} + 33'd1;

  always_comb begin
    o_result = 32'h0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    if (i_alu_op == AOP_PASS) begin
      o_result = i_a;
    end else begin
      case (w_fn)
        FN_ADD: begin
          o_result = w_sum[31:0];
          w_c      = w_sum[32];
          w_v      = (i_a[31] == w_b[31]) && (w_sum[31] != i_a[31]);
        end
        FN_SUB: begin
          o_result = w_diff[31:0];
          w_c      = w_diff[32];
          w_v      = (i_a[31] != w_b[31]) && (w_diff[31] != i_a[31]);
        end
        FN_AND: o_result = i_a & w_b;
        FN_OR:  o_result = i_a | w_b;
        FN_XOR: o_result = i_a ^ w_b;
        FN_NOT: o_result = ~i_a;
        FN_SHL: o_result = i_a << w_b[4:0];
        FN_SHR: o_result = i_a >> w_b[4:0];
        default: o_result = 32'h0;
      endcase
    end
  end

  always_comb begin
    o_stat       = 4'b0000;
    o_stat[SR_C] = w_c;
    o_stat[SR_V] = w_v;
    o_stat[SR_N] = o_result[31];
    o_stat[SR_Z] = (o_result == 32'h0);
  end

endmodule

// File: rtl/sisc_exec_unit.sv
// SISC multicycle control/execute block: five-phase sequencer with Moore
// datapath controls, the ALU and the 16-bit branch-target adder.
module sisc_exec_unit
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] ir,
  input  logic [3:0]  sr,
  input  logic [15:0] pc_out,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  output logic [31:0] alu_result,
  output logic [3:0]  stat,
  output logic        stat_en,
  output logic [15:0] br_addr,
  output logic [1:0]  alu_op,
  output logic        br_sel,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        rb_sel,
  output logic        ir_load,
  output logic        mm_sel,
  output logic        dm_we
);

  state_t      r_state;
  logic [3:0]  w_op;
  logic [3:0]  w_mm;
  logic [15:0] w_imm;
  logic        w_is_alu;
  logic        w_is_br;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_rel;
  logic        w_hit;
  logic        w_taken;
  logic [1:0]  w_aop;
  logic        w_unused;

  assign w_op     = ir[31:28];
  assign w_mm     = ir[27:24];
  assign w_imm    = ir[15:0];
  assign w_unused = ^ir[23:16];

  assign w_is_alu = (w_op == OP_ALU) || (w_op == OP_ALUI);
  assign w_is_br  = (w_op == OP_BRA) || (w_op == OP_BRR) ||
                    (w_op == OP_BNE) || (w_op == OP_BNR);
  assign w_is_ld  = (w_op == OP_LOD);
  assign w_is_st  = (w_op == OP_STR);
  assign w_rel    = (w_op == OP_BRR) || (w_op == OP_BNR);
  assign w_hit    = (w_mm & sr) != 4'b0000;
  // BRA/BRR branch on any masked flag set, BNE/BNR on none set.
  assign w_taken  = w_is_br &&
                    (((w_op == OP_BRA) || (w_op == OP_BRR)) ? w_hit : !w_hit);

  always_comb begin
    w_aop = AOP_PASS;
    if (w_op == OP_ALU)             w_aop = AOP_REG;
    else if (w_op == OP_ALUI)       w_aop = AOP_IMM;
    else if (w_is_ld || w_is_st)    w_aop = AOP_ADDR;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= ST_START0;
    end else begin
      case (r_state)
        ST_START0:    r_state <= ST_START1;
        ST_START1:    r_state <= ST_FETCH;
        ST_FETCH:     r_state <= ST_DECODE;
        ST_DECODE:    r_state <= (w_op == OP_HLT) ? ST_HALT : ST_EXECUTE;
        ST_EXECUTE:   r_state <= ST_MEM;
        ST_MEM:       r_state <= ST_WRITEBACK;
        ST_WRITEBACK: r_state <= ST_FETCH;
        ST_HALT:      r_state <= ST_HALT;
        default:      r_state <= ST_START0;
      endcase
    end
  end

  // Controls decode straight from the state register, so an asynchronous
  // reset drops every write enable immediately.
  always_comb begin
    pc_rst   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rb_sel   = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    br_sel   = 1'b0;
    alu_op   = AOP_REG;
    case (r_state)
      ST_START0: pc_rst = 1'b1;
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK: begin
        alu_op = w_aop;
        br_sel = w_rel;
        rb_sel = w_is_st;
        case (r_state)
          ST_EXECUTE: begin
            stat_en  = w_is_alu;
            pc_sel   = w_taken;
            pc_write = w_taken;
          end
          ST_MEM: begin
            mm_sel = (w_is_ld || w_is_st) && w_mm[0];
            dm_we  = w_is_st;
          end
          ST_WRITEBACK: begin
            rf_we  = w_is_alu || w_is_ld;
            wb_sel = w_is_ld;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  sisc_alu_core u_alu (
    .i_a      (rsa),
    .i_rsb    (rsb),
    .i_imm    (w_imm),
    .i_fn     (w_mm),
    .i_alu_op (alu_op),
    .o_result (alu_result),
    .o_stat   (stat)
  );

  assign br_addr = br_sel ? (pc_out + w_imm) : w_imm;

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Self-checking bench for sisc_exec_unit: directed vector table, hand-written
// reset/halt sequences and randomized instructions against a reference model.
module tb_sisc_exec_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] ir;
  logic [3:0]  sr;
  logic [15:0] pc_out;
  logic [31:0] rsa, rsb;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic        stat_en;
  logic [15:0] br_addr;
  logic [1:0]  alu_op;
  logic        br_sel, rf_we, wb_sel, pc_rst, pc_write, pc_sel;
  logic        rb_sel, ir_load, mm_sel, dm_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sisc_exec_unit dut (
    .clk(clk), .rst_f(rst_f), .ir(ir), .sr(sr), .pc_out(pc_out),
    .rsa(rsa), .rsb(rsb), .alu_result(alu_result), .stat(stat),
    .stat_en(stat_en), .br_addr(br_addr), .alu_op(alu_op), .br_sel(br_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .rb_sel(rb_sel), .ir_load(ir_load), .mm_sel(mm_sel),
    .dm_we(dm_we)
  );

  logic [12:0] act_ctrl;
  assign act_ctrl = {pc_rst, ir_load, pc_write, pc_sel, stat_en, rf_we, wb_sel,
                     rb_sel, mm_sel, dm_we, br_sel, alu_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Phase: -2 START0, -1 START1, 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WRITEBACK, 5 HALT
  function automatic logic [12:0] exp_ctrl(input int ph, input logic [31:0] i, input logic [3:0] s);
    logic [3:0] op, mm;
    bit is_alu, is_br, is_ld, is_st, rel, taken;
    bit e_rst, e_irl, e_pcw, e_pcs, e_st, e_rfw, e_wbs, e_rbs, e_mms, e_dmw, e_brs;
    logic [1:0] aop, e_aop;
    op = i[31:28];
    mm = i[27:24];
    is_alu = (op == 4'h1) || (op == 4'h2);
    is_br  = (op >= 4'h4) && (op <= 4'h7);
    is_ld  = (op == 4'h8);
    is_st  = (op == 4'h9);
    rel    = (op == 4'h5) || (op == 4'h7);
    taken  = is_br && (((op == 4'h4) || (op == 4'h5)) ? ((mm & s) != 0) : ((mm & s) == 0));
    aop = (op == 4'h1) ? 2'd0 : (op == 4'h2) ? 2'd1 : (is_ld || is_st) ? 2'd2 : 2'd3;
    {e_rst, e_irl, e_pcw, e_pcs, e_st, e_rfw, e_wbs, e_rbs, e_mms, e_dmw, e_brs} = '0;
    e_aop = 2'd0;
    if (ph == -2) e_rst = 1;
    if (ph == 0) begin e_irl = 1; e_pcw = 1; end
    if (ph >= 1 && ph <= 4) begin e_aop = aop; e_brs = rel; e_rbs = is_st; end
    if (ph == 2) begin e_st = is_alu; e_pcs = taken; e_pcw = taken; end
    if (ph == 3) begin e_mms = (is_ld || is_st) && mm[0]; e_dmw = is_st; end
    if (ph == 4) begin e_rfw = is_alu || is_ld; e_wbs = is_ld; end
    return {e_rst, e_irl, e_pcw, e_pcs, e_st, e_rfw, e_wbs, e_rbs, e_mms, e_dmw, e_brs, e_aop};
  endfunction

  // Reference ALU from the arithmetic rules, using wide integer arithmetic.
  task automatic ref_alu(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b0,
                         output logic [31:0] res, output logic [3:0] st);
    logic [3:0] op, fn;
    logic [31:0] b;
    longint sa, sb, s;
    bit c, v, pass;
    op = i[31:28];
    fn = i[27:24];
    pass = 0;
    b = b0;
    if (op == 4'h2) b = 32'($signed(i[15:0]));
    else if (op == 4'h8 || op == 4'h9) begin b = {16'h0, i[15:0]}; fn = 4'h1; end
    else if (op != 4'h1) pass = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 0; v = 0;
    if (pass) res = a;
    else case (fn)
      4'h1: begin
        res = a + b;
        c = (longint'(a) + longint'(b)) >= 64'sd4294967296;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: begin
        res = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = a ^ b;
      4'h6: res = ~a;
      4'h7: res = a << b[4:0];
      4'h8: res = a >> b[4:0];
      default: res = 32'h0;
    endcase
    st = {c, v, res[31], res == 32'h0};
  endtask

  task automatic do_reset;
    rst_f = 1'b0;
    step;
    step;
    chk("reset_start0", {19'h0, act_ctrl}, {19'h0, exp_ctrl(-2, ir, sr)});
    rst_f = 1'b1;
    step;
    chk("reset_start1", {19'h0, act_ctrl}, {19'h0, exp_ctrl(-1, ir, sr)});
    step;
  endtask

  // Entered at a FETCH sample point; leaves at the next FETCH (or HALT / reset).
  task automatic run_instr(input logic [31:0] i_ir, input logic [3:0] i_sr,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] pc,
                           input logic [31:0] eres, input logic [3:0] est,
                           input bit cbr, input logic [15:0] ebr,
                           input bit ctk, input bit etk, input int abort_at);
    ir = i_ir; sr = i_sr; rsa = a; rsb = b; pc_out = pc;
    for (int ph = 0; ph <= 4; ph++) begin
      chk($sformatf("ctrl_ph%0d_ir%h", ph, i_ir), {19'h0, act_ctrl}, {19'h0, exp_ctrl(ph, i_ir, i_sr)});
      if (ph == 2) begin
        chk($sformatf("alu_result_ir%h", i_ir), alu_result, eres);
        chk($sformatf("stat_ir%h", i_ir), {28'h0, stat}, {28'h0, est});
        if (cbr) chk($sformatf("br_addr_ir%h", i_ir), {16'h0, br_addr}, {16'h0, ebr});
        if (ctk) chk($sformatf("taken_ir%h", i_ir), {31'h0, pc_write}, {31'h0, etk});
      end
      if (ph == abort_at) begin
        rst_f = 1'b0;
        #1;
        chk("abort_ctrl", {19'h0, act_ctrl}, {19'h0, exp_ctrl(-2, i_ir, i_sr)});
        return;
      end
      if (ph == 1 && i_ir[31:28] == 4'hF) begin
        for (int k = 0; k < 25; k++) begin
          step;
          chk("halt_ctrl", {19'h0, act_ctrl}, {19'h0, exp_ctrl(5, i_ir, i_sr)});
        end
        return;
      end
      step;
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  sr;
    logic [31:0] rsa, rsb;
    logic [15:0] pc;
    logic [31:0] res;
    logic [3:0]  st;
    bit          cbr;
    logic [15:0] br;
    bit          tk;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rir, ra, rb, eres;
    logic [3:0]  rsr, est;
    logic [15:0] rpc, ebr;
    logic [3:0]  ops [11];
    logic [31:0] edge_vals [4];
    bit is_br;

    tbl.push_back('{32'h11312000, 4'h0, 32'h7FFFFFFF, 32'h00000001, 16'h0000, 32'h80000000, 4'b0110, 0, 16'h0, 0});
    tbl.push_back('{32'h12312000, 4'h0, 32'h00000005, 32'h00000005, 16'h0000, 32'h00000000, 4'b1001, 0, 16'h0, 0});
    tbl.push_back('{32'h12312000, 4'h0, 32'h80000000, 32'h00000001, 16'h0000, 32'h7FFFFFFF, 4'b1100, 0, 16'h0, 0});
    tbl.push_back('{32'h12312000, 4'h0, 32'h00000003, 32'h00000005, 16'h0000, 32'hFFFFFFFE, 4'b0010, 0, 16'h0, 0});
    tbl.push_back('{32'h13312000, 4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0000, 32'hF000F000, 4'b0010, 0, 16'h0, 0});
    tbl.push_back('{32'h14312000, 4'h0, 32'h0000000F, 32'h000000F0, 16'h0000, 32'h000000FF, 4'b0000, 0, 16'h0, 0});
    tbl.push_back('{32'h15312000, 4'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'h0000, 32'h00000000, 4'b0001, 0, 16'h0, 0});
    tbl.push_back('{32'h16312000, 4'h0, 32'h00000000, 32'h12345678, 16'h0000, 32'hFFFFFFFF, 4'b0010, 0, 16'h0, 0});
    tbl.push_back('{32'h17312000, 4'h0, 32'h00000001, 32'h0000003F, 16'h0000, 32'h80000000, 4'b0010, 0, 16'h0, 0});
    tbl.push_back('{32'h18312000, 4'h0, 32'h80000000, 32'h00000024, 16'h0000, 32'h08000000, 4'b0000, 0, 16'h0, 0});
    tbl.push_back('{32'h19312000, 4'h0, 32'h00000005, 32'h00000005, 16'h0000, 32'h00000000, 4'b0001, 0, 16'h0, 0});
    tbl.push_back('{32'h2110FFFF, 4'h0, 32'h00000001, 32'h00001234, 16'h0000, 32'h00000000, 4'b1001, 0, 16'h0, 0});
    tbl.push_back('{32'h22108000, 4'h0, 32'h00000000, 32'h00000000, 16'h0000, 32'h00008000, 4'b0000, 0, 16'h0, 0});
    tbl.push_back('{32'h51000010, 4'h1, 32'h00000000, 32'h00000000, 16'h0005, 32'h00000000, 4'b0001, 1, 16'h0015, 1});
    tbl.push_back('{32'h51000010, 4'h0, 32'h00000000, 32'h00000000, 16'h0005, 32'h00000000, 4'b0001, 1, 16'h0015, 0});
    tbl.push_back('{32'h4F001234, 4'h4, 32'h00000000, 32'h00000000, 16'h0077, 32'h00000000, 4'b0001, 1, 16'h1234, 1});
    tbl.push_back('{32'h4F001234, 4'h0, 32'h00000000, 32'h00000000, 16'h0077, 32'h00000000, 4'b0001, 1, 16'h1234, 0});
    tbl.push_back('{32'h62000040, 4'h1, 32'h00000000, 32'h00000000, 16'h0077, 32'h00000000, 4'b0001, 1, 16'h0040, 1});
    tbl.push_back('{32'h7100FFF0, 4'h1, 32'h00000000, 32'h00000000, 16'h0020, 32'h00000000, 4'b0001, 1, 16'h0010, 0});
    tbl.push_back('{32'h7100FFF0, 4'h2, 32'h00000000, 32'h00000000, 16'h0020, 32'h00000000, 4'b0001, 1, 16'h0010, 1});
    tbl.push_back('{32'h91100020, 4'h0, 32'h00000100, 32'hDEADBEEF, 16'h0000, 32'h00000120, 4'b0000, 0, 16'h0, 0});
    tbl.push_back('{32'h80208000, 4'h0, 32'h00001000, 32'h00000000, 16'h0000, 32'h00009000, 4'b0000, 0, 16'h0, 0});
    tbl.push_back('{32'h80200001, 4'h0, 32'hFFFFFFFF, 32'h00000000, 16'h0000, 32'h00000000, 4'b1001, 0, 16'h0, 0});
    tbl.push_back('{32'h00000000, 4'h0, 32'h80000000, 32'h00000000, 16'h0000, 32'h80000000, 4'b0010, 0, 16'h0, 0});
    tbl.push_back('{32'h3F000000, 4'h0, 32'h00000007, 32'h00000000, 16'h0000, 32'h00000007, 4'b0000, 0, 16'h0, 0});

    ir = 32'h0; sr = 4'h0; pc_out = 16'h0; rsa = 32'h0; rsb = 32'h0;
    rst_f = 1'b0;
    do_reset;
    chk("fetch_after_reset", {19'h0, act_ctrl}, {19'h0, 13'b0_1_1_0000000000});

    foreach (tbl[n])
      run_instr(tbl[n].ir, tbl[n].sr, tbl[n].rsa, tbl[n].rsb, tbl[n].pc,
                tbl[n].res, tbl[n].st, tbl[n].cbr, tbl[n].br, tbl[n].cbr, tbl[n].tk, -1);

    // Reset in WRITEBACK of an ALU op and in MEM of a store must kill the write enables.
    run_instr(32'h11312000, 4'h0, 32'h1, 32'h2, 16'h0, 32'h3, 4'b0000, 0, 16'h0, 0, 0, 4);
    do_reset;
    run_instr(32'h91100020, 4'h0, 32'h100, 32'h0, 16'h0, 32'h120, 4'b0000, 0, 16'h0, 0, 0, 3);
    do_reset;

    // Halt holds every control low until reset.
    run_instr(32'hF0000000, 4'h0, 32'h0, 32'h0, 16'h0, 32'h0, 4'b0001, 0, 16'h0, 0, 0, -1);
    do_reset;

    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    edge_vals = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    for (int n = 0; n < 250; n++) begin
      rir = $urandom;
      rir[31:28] = ops[$urandom_range(0, 10)];
      rsr = 4'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rpc = 16'($urandom);
      ref_alu(rir, ra, rb, eres, est);
      is_br = (rir[31:28] >= 4'h4) && (rir[31:28] <= 4'h7);
      if (rir[31:28] == 4'h5 || rir[31:28] == 4'h7)
        ebr = 16'((int'(rpc) + int'(rir[15:0])) % 65536);
      else
        ebr = rir[15:0];
      run_instr(rir, rsr, ra, rb, rpc, eres, est, is_br, ebr, 0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
